mnist_image_reader: RTL and testbench
=====================================

Name: mnist_image_reader

Overview:
- Read-side counterpart of the drawing-grid writer: scans the 28x28 image memory in raster order over its synchronous read port.
- Streams each pixel word to the network input stage over a valid/ready handshake.
- Tracks position, last-pixel and nonzero-pixel count so the classifier can start inference on a completed frame.

Parameters:
- GRID_SIZE, 28, pixels per row and per column
- NUM_PIXELS, 784, GRID_SIZE*GRID_SIZE; words read per frame
- DATA_W, 32, width of a signed image-memory word
- ADDR_W, 16, image-memory read address width

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame scan when idle
- abort  in  1  one-cycle pulse; terminates an in-progress scan
- read_addr  out  ADDR_W  image-memory read address
- mem_data  in  DATA_W  signed read data, valid exactly 1 cycle after read_addr
- px_data  out  DATA_W  signed pixel word
- px_valid  out  1  px_data/px_index/px_row/px_col/px_last are valid
- px_ready  in  1  consumer accepts when px_valid && px_ready
- px_index  out  10  linear pixel index 0..783
- px_row  out  5  index / GRID_SIZE
- px_col  out  5  index % GRID_SIZE
- px_last  out  1  high with index 783
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after last pixel handshake
- set_count  out  10  count of accepted pixels with px_data != 0 in current/last frame

Behaviour:
- Reset values: read_addr=0, px_valid=0, px_data=0, px_index=0, px_row=0, px_col=0, px_last=0, busy=0, done=0, set_count=0, state IDLE, buffer empty.
- Reset mid-scan returns to IDLE immediately; no done pulse.
- States:
  - IDLE: start -> STREAM, clear issue counter, set_count, row/col; busy=1 next cycle.
  - STREAM: issue reads while (occupancy + in_flight) < 2; issue counter 0..783. After issuing 783 -> DRAIN.
  - DRAIN: no new reads; when final pixel (px_last) handshakes -> DONE.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- read_addr = issue counter, held (not incremented) on non-issue cycles; in_flight is a 1-cycle flag set on issue.
- Read data lands in a 2-entry FIFO one cycle after issue. The head drives px_* outputs.
  - Credit rule guarantees no overflow regardless of px_ready; overflow is a bench assertion.
- Throughput: with px_ready held high, one pixel per cycle after a 2-cycle start latency.
  - start seen at cycle 0, first read issued cycle 1, px_valid first high cycle 2 (wait cycle 1->2: mem latency + FIFO write).
- Handshake rules:
  - px_valid never deasserts and px_* never changes while px_valid && !px_ready.
  - px_valid does not depend combinationally on px_ready.
- Indexing: px_index/px_row/px_col are stored per FIFO entry.
  - col wraps 27->0 with row+1.
  - px_last = (index == NUM_PIXELS-1).
- set_count increments by 1 on each handshake where px_data != 0 (signed compare to zero).
  - Saturates at 784 (cannot exceed by construction).
  - Holds its value after done until next start.
- start while busy is ignored. start and abort same cycle in IDLE: abort wins, stay IDLE.
- abort in STREAM/DRAIN: flush FIFO, drop in-flight read, px_valid=0 next cycle, busy=0, -> IDLE, no done pulse, set_count holds partial value.

Test Plan:
- Memory preloaded with value i at address i, px_ready=1, start pulse -> 784 handshakes, px_index=px_data=0..783 in order, px_last only at 783, done pulse 1 cycle after it, total 787 cycles start-to-done.
- Pixels (row 14, col 14) and (0,27) set to 1, rest 0 -> set_count=2; handshake at index 27 shows px_row=0, px_col=27; index 28 shows px_row=1, px_col=0.
- px_ready randomly toggled 50% -> identical ordered stream, px_* stable while stalled, no FIFO overflow, read_addr never more than 2 ahead of last accepted index.
- px_ready held 0 for 100 cycles after start -> exactly 2 reads issued, px_index=0 held, then resumes with no loss when ready rises.
- abort at pixel 400 -> px_valid=0 and busy=0 next cycle, no done, set_count = nonzero count of indices 0..399 accepted; new start rescans from index 0.
- reset asserted during DRAIN -> all outputs at reset values next cycle; start while busy and start+abort in IDLE both ignored.

Source files
------------

// File: rtl/mnist_image_reader.sv
// mnist_image_reader: raster-scans the 28x28 image memory and streams pixels over valid/ready
// Ports: CLOCK_50/reset (sync, active-high); start/abort control pulses;
//   read_addr/mem_data form the synchronous image-memory read port (1-cycle latency);
//   px_* is the pixel stream (valid/ready) with per-pixel index, row, col and last flag;
//   busy/done report frame progress; set_count counts nonzero pixels accepted this frame.
module mnist_image_reader #(
  parameter int GRID_SIZE  = 28,
  parameter int NUM_PIXELS = 784,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        read_addr,
  input  logic signed [DATA_W-1:0] mem_data,
  output logic signed [DATA_W-1:0] px_data,
  output logic                     px_valid,
  input  logic                     px_ready,
  output logic [9:0]               px_index,
  output logic [4:0]               px_row,
  output logic [4:0]               px_col,
  output logic                     px_last,
  output logic                     busy,
  output logic                     done,
  output logic [9:0]               set_count
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic signed [DATA_W-1:0] f_data [2];
  logic [9:0] f_idx [2];
  logic [4:0] f_row [2];
  logic [4:0] f_col [2];
  logic wp, rp, in_flight, issue, pop, kill, go, last_addr;
  logic [1:0] occ;
  logic [9:0] w_idx;
  logic [4:0] w_row, w_col;
  always_comb begin
    go        = state == IDLE && start && !abort;
    kill      = abort && (state == STREAM || state == DRAIN);
    px_valid  = occ != 2'd0;
    pop       = px_valid && px_ready && !kill;
    last_addr = read_addr == ADDR_W'(NUM_PIXELS - 1);
    // a pop this cycle frees a slot, so the credit check sees it to keep one pixel per cycle
    issue     = state == STREAM && !kill && ({1'b0, occ} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop});
    px_data   = px_valid ? f_data[rp] : '0;
    px_index  = px_valid ? f_idx[rp] : '0;
    px_row    = px_valid ? f_row[rp] : '0;
    px_col    = px_valid ? f_col[rp] : '0;
    px_last   = px_valid && f_idx[rp] == 10'(NUM_PIXELS - 1);
    busy      = state == STREAM || state == DRAIN;
    done      = state == DONE;
    state_nx  = state;
    unique case (state)
      IDLE:    state_nx = go ? STREAM : IDLE;
      STREAM:  state_nx = kill ? IDLE : (issue && last_addr) ? DRAIN : STREAM;
      DRAIN:   state_nx = kill ? IDLE : (pop && px_last) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      read_addr <= '0;
      in_flight <= 1'b0;
      occ       <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      w_idx     <= '0;
      w_row     <= '0;
      w_col     <= '0;
      set_count <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        read_addr <= '0;
        in_flight <= 1'b0;
        occ       <= '0;
        wp        <= 1'b0;
        rp        <= 1'b0;
        w_idx     <= '0;
        w_row     <= '0;
        w_col     <= '0;
        set_count <= '0;
      end else if (kill) begin
        in_flight <= 1'b0;
        occ       <= '0;
        wp        <= 1'b0;
        rp        <= 1'b0;
      end else begin
        in_flight <= issue;
        if (issue && !last_addr) read_addr <= read_addr + 1'b1;
        if (in_flight) begin
          wp    <= ~wp;
          w_idx <= w_idx + 1'b1;
          w_col <= (w_col == 5'(GRID_SIZE - 1)) ? '0 : w_col + 1'b1;
          w_row <= (w_col == 5'(GRID_SIZE - 1)) ? w_row + 1'b1 : w_row;
        end
        if (pop) rp <= ~rp;
        occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        if (pop && px_data != 0 && set_count != 10'(NUM_PIXELS)) set_count <= set_count + 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (in_flight && !kill && !go) begin
      f_data[wp] <= mem_data;
      f_idx[wp]  <= w_idx;
      f_row[wp]  <= w_row;
      f_col[wp]  <= w_col;
    end
  end
endmodule

// File: tb/tb_mnist_image_reader.sv
// tb_mnist_image_reader: directed bench with a frame-level pixel-stream model for mnist_image_reader
module tb_mnist_image_reader;
  localparam int NP = 784;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, px_ready = 1'b0;
  logic [15:0] read_addr;
  logic signed [31:0] mem_data = '0, px_data;
  logic px_valid, px_last, busy, done;
  logic [9:0] px_index, set_count;
  logic [4:0] px_row, px_col;
  logic signed [31:0] mem [NP];
  int vectors = 0, miscompares = 0;
  bit run = 0;
  // frame-level model state
  bit mbusy = 0, mdone = 0, stall = 0;
  int exp_next = 0, mcnt = 0;
  logic [9:0] s_idx;
  logic signed [31:0] s_data;

  mnist_image_reader dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
    .read_addr(read_addr), .mem_data(mem_data), .px_data(px_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_index(px_index),
    .px_row(px_row), .px_col(px_col), .px_last(px_last), .busy(busy),
    .done(done), .set_count(set_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) mem_data <= (read_addr < 16'(NP)) ? mem[read_addr] : '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) if (run) begin
    chk("busy", 64'(busy), 64'(mbusy));
    chk("done", 64'(done), 64'(mdone));
    chk("set_count", 64'(set_count), 64'(mcnt));
    if (!mbusy) chk("valid_idle", 64'(px_valid), 0);
    if (stall) begin
      chk("stall_valid", 64'(px_valid), 1);
      chk("stall_idx", 64'(px_index), 64'(s_idx));
      chk("stall_data", 64'(px_data), 64'(s_data));
    end
    if (mbusy && px_valid) begin
      chk("px_index", 64'(px_index), 64'(exp_next));
      chk("px_data", 64'(px_data), 64'(mem[exp_next]));
      chk("px_row", 64'(px_row), 64'(exp_next / 28));
      chk("px_col", 64'(px_col), 64'(exp_next % 28));
      chk("px_last", 64'(px_last), 64'(exp_next == NP - 1));
    end
    if (mbusy) chk("credit", 64'(int'(read_addr) - exp_next <= 2), 1);
    stall = px_valid && !px_ready && !abort && !reset;
    s_idx = px_index;
    s_data = px_data;
    mdone = 0;
    if (reset) begin
      mbusy = 0; mcnt = 0; exp_next = 0; stall = 0;
    end else if (mbusy && abort) begin
      mbusy = 0; stall = 0;
    end else if (!mbusy && !mdone && start && !abort) begin
      mbusy = 1; mcnt = 0; exp_next = 0;
    end else if (mbusy && px_valid && px_ready) begin
      if (mem[exp_next] != 0) mcnt++;
      if (exp_next == NP - 1) begin mbusy = 0; mdone = 1; end
      exp_next++;
    end
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd, output int n);
    n = 0;
    while (!done && n < 5000) begin
      if (rnd) px_ready = 1'($urandom % 2);
      tick;
      n++;
    end
    chk("done_seen", 64'(done), 1);
    px_ready = 1'b1;
    tick;
    chk("done_one_cycle", 64'(done), 0);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(px_valid && int'(px_index) == idx) && n < 2000) begin
      tick;
      n++;
    end
    chk("wait_idx_reached", 64'(px_index), 64'(idx));
  endtask

  task automatic chk_reset_vals;
    chk("rst_read_addr", 64'(read_addr), 0);
    chk("rst_px_valid", 64'(px_valid), 0);
    chk("rst_px_data", 64'(px_data), 0);
    chk("rst_px_index", 64'(px_index), 0);
    chk("rst_px_row", 64'(px_row), 0);
    chk("rst_px_col", 64'(px_col), 0);
    chk("rst_px_last", 64'(px_last), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_set_count", 64'(set_count), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NP; i++) mem[i] = i;
    tick;
    tick;
    chk_reset_vals;
    reset = 1'b0;
    run = 1;
    tick;
    // full frame, ready always high: 787 edges from start to done
    px_ready = 1'b1;
    pulse_start;
    chk("busy_after_start", 64'(busy), 1);
    run_to_done(0, n);
    chk("start_to_done_cycles", 64'(n + 1), 787);
    chk("count_ramp", 64'(set_count), 783);
    // two set pixels, row/col wrap
    for (int i = 0; i < NP; i++) mem[i] = 0;
    mem[14 * 28 + 14] = 1;
    mem[27] = 1;
    pulse_start;
    wait_idx(27);
    chk("row_at_27", 64'(px_row), 0);
    chk("col_at_27", 64'(px_col), 27);
    tick;
    chk("row_at_28", 64'(px_row), 1);
    chk("col_at_28", 64'(px_col), 0);
    run_to_done(0, n);
    chk("count_two", 64'(set_count), 2);
    // random backpressure, all pixels nonzero (including negatives) -> saturating count
    for (int i = 0; i < NP; i++) mem[i] = i * 3 - 500;
    pulse_start;
    run_to_done(1, n);
    chk("count_full", 64'(set_count), 784);
    // ready held low: only two reads go out
    px_ready = 1'b0;
    pulse_start;
    repeat (100) tick;
    chk("held_read_addr", 64'(read_addr), 2);
    chk("held_valid", 64'(px_valid), 1);
    chk("held_index", 64'(px_index), 0);
    px_ready = 1'b1;
    run_to_done(0, n);
    chk("count_after_hold", 64'(set_count), 784);
    // abort at pixel 400
    for (int i = 0; i < NP; i++) mem[i] = i;
    pulse_start;
    wait_idx(400);
    px_ready = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_valid", 64'(px_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_count", 64'(set_count), 399);
    repeat (3) begin
      tick;
      chk("abort_no_done", 64'(done), 0);
    end
    px_ready = 1'b1;
    pulse_start;
    wait_idx(0);
    chk("rescan_index", 64'(px_index), 0);
    // start while busy is ignored
    repeat (50) tick;
    pulse_start;
    run_to_done(0, n);
    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 0);
    tick;
    chk("start_abort_valid", 64'(px_valid), 0);
    // reset during DRAIN
    pulse_start;
    n = 0;
    while (read_addr != 16'(NP - 1) && n < 2000) begin
      tick;
      n++;
    end
    tick;
    chk("in_drain", 64'(busy), 1);
    reset = 1'b1;
    tick;
    chk_reset_vals;
    reset = 1'b0;
    repeat (3) tick;
    chk("no_done_after_reset", 64'(done), 0);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
